uart_cmd_parser: RTL

Frame parser between the UART receiver and the home controller. Consumes received bytes through the receiver's `rdy`/`rdy_clr` handshake and assembles 4-byte command frames (sync, device, value, checksum). Valid frames become a one-cycle command strobe toward the controller. Every completed frame queues an ACK or NAK byte toward the UART transmitter's `i_TX_DV`/`i_TX_Byte` inputs.

---
 rtl/uart_cmd_parser_if.sv | 29 ++
 rtl/uart_cmd_parser.sv | 133 +++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser_if
// Brief    : Receiver, transmitter and command-strobe signals of the parser.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_rdy_clr;
    logic       tx_active;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       cmd_valid;
    logic [3:0] cmd_dev;
    logic [7:0] cmd_val;
    logic       frame_err;

    modport master (
        input  rx_data, rx_rdy, tx_active,
        output rx_rdy_clr, tx_dv, tx_byte, cmd_valid, cmd_dev, cmd_val, frame_err
    );

    modport slave (
        output rx_data, rx_rdy, tx_active,
        input  rx_rdy_clr, tx_dv, tx_byte, cmd_valid, cmd_dev, cmd_val, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_parser
// Brief    : Assembles 4-byte UART command frames and replies with ACK/NAK.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         NUM_DEV        = 12,
    parameter logic [7:0] ACK_BYTE       = 8'h06,
    parameter logic [7:0] NAK_BYTE       = 8'h15,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  wire              clk,
    input  wire              rst_n,
    uart_cmd_parser_if.master bus
);
    localparam int         c_TW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0] c_NUM_DEV   = 9'(NUM_DEV);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_CHK  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_cnt;
    logic [7:0]      r_dev_raw;
    logic [7:0]      r_val;
    logic [7:0]      r_reply;
    logic            r_rdy_clr;
    logic            r_tx_dv;
    logic [7:0]      r_tx_byte;
    logic            r_cmd_valid;
    logic [3:0]      r_cmd_dev;
    logic [7:0]      r_cmd_val;
    logic            r_frame_err;

    logic       w_accept;
    logic       w_in_frame;
    logic       w_timeout;
    logic [7:0] w_sum;
    logic       w_good;

    // The cycle carrying the clear pulse still sees the old rx_rdy, so it is skipped.
    assign w_accept   = bus.rx_rdy && !r_rdy_clr && (r_state != S_RESP);
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CHK);
    assign w_timeout  = w_in_frame && !w_accept && (r_cnt == c_TO_LAST);
    assign w_sum      = r_dev_raw + r_val;
    assign w_good     = (bus.rx_data == w_sum) && ({1'b0, r_dev_raw} < c_NUM_DEV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dev_raw   <= '0;
            r_val       <= '0;
            r_reply     <= '0;
            r_rdy_clr   <= 1'b0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_dev   <= '0;
            r_cmd_val   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_rdy_clr   <= w_accept;
            r_tx_dv     <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_cnt       <= (w_in_frame && !w_accept && !w_timeout) ? r_cnt + c_TW'(1) : '0;

            if (w_timeout) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept && (bus.rx_data == SYNC_BYTE))
                            r_state <= S_ADDR;
                    end
                    S_ADDR: begin
                        if (w_accept) begin
                            r_dev_raw <= bus.rx_data;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_accept) begin
                            r_val   <= bus.rx_data;
                            r_state <= S_CHK;
                        end
                    end
                    S_CHK: begin
                        if (w_accept) begin
                            r_state <= S_RESP;
                            if (w_good) begin
                                r_cmd_dev   <= r_dev_raw[3:0];
                                r_cmd_val   <= r_val;
                                r_cmd_valid <= 1'b1;
                                r_reply     <= ACK_BYTE;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_reply     <= NAK_BYTE;
                            end
                        end
                    end
                    S_RESP: begin
                        if (!bus.tx_active) begin
                            r_tx_byte <= r_reply;
                            r_tx_dv   <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.rx_rdy_clr = r_rdy_clr;
    assign bus.tx_dv      = r_tx_dv;
    assign bus.tx_byte    = r_tx_byte;
    assign bus.cmd_valid  = r_cmd_valid;
    assign bus.cmd_dev    = r_cmd_dev;
    assign bus.cmd_val    = r_cmd_val;
    assign bus.frame_err  = r_frame_err;
endmodule
`default_nettype wire
